// File: rtl/display_tx_pacer.sv
// rtl/display_tx_pacer.sv - DSP character FIFO and display TX strobe pacer (optional TXPACE_THROTTLE_EN)
module display_tx_pacer #(
  parameter int DEPTH    = 16,
  parameter int PACE_DIV = 16667
) (
  input  logic                     sys_clock,
  input  logic                     reset_n,
  input  logic                     cpu_clken,
  input  logic                     cpu_wr,
  input  logic [7:0]               cpu_din,
  input  logic                     flush,
  output logic                     dsp_busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     disp_address,
  output logic                     disp_w_en,
  output logic [7:0]               disp_din
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_next;
  logic [1:0]    state;
  logic          tick_cnt;
  logic          push;
  logic          pop;
  logic          wr_drop;

`ifdef TXPACE_THROTTLE_EN
  localparam int PW = $clog2(PACE_DIV + 1);
  localparam logic [PW-1:0] PACE_LAST = PW'(PACE_DIV - 1);
  localparam logic [PW-1:0] PACE_ONE  = PW'(1);
  logic [PW-1:0] pace_cnt;
`endif

  // flush wins over a same-cycle push; pops only start from IDLE
  assign push    = cpu_clken & cpu_wr & ~dsp_busy & ~flush;
  assign wr_drop = cpu_clken & cpu_wr & dsp_busy;
  assign pop     = (state == ST_IDLE) && (fifo_count != '0) && !flush;

  // next occupancy: simultaneous push and pop cancel out
  always_comb begin
    count_next = fifo_count;
    if (push && !pop)
      count_next = fifo_count + CNT_ONE;
    else if (pop && !push)
      count_next = fifo_count - CNT_ONE;
  end

  // FIFO storage; no reset needed, entries are only read once counted
  always_ff @(posedge sys_clock) begin
    if (push)
      mem[wr_ptr] <= cpu_din;
  end

  // pointers, occupancy, busy and sticky overflow
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      dsp_busy   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_drop)
        overflow <= 1'b1;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        dsp_busy   <= 1'b0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        fifo_count <= count_next;
        dsp_busy   <= (count_next == CNT_FULL);
      end
    end
  end

  // delivery FSM driving the display hold/release strobe
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      tick_cnt     <= 1'b0;
      disp_w_en    <= 1'b0;
      disp_address <= 1'b1;
      disp_din     <= 8'h00;
`ifdef TXPACE_THROTTLE_EN
      pace_cnt     <= '0;
`endif
    end else if (flush) begin
      state        <= ST_IDLE;
      tick_cnt     <= 1'b0;
      disp_w_en    <= 1'b0;
      disp_address <= 1'b1;
`ifdef TXPACE_THROTTLE_EN
      pace_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            disp_din     <= mem[rd_ptr];
            disp_w_en    <= 1'b1;
            disp_address <= 1'b0;
            state        <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (cpu_clken) begin
            if (tick_cnt) begin
              tick_cnt  <= 1'b0;
              disp_w_en <= 1'b0;
              state     <= ST_RELEASE;
            end else begin
              tick_cnt <= 1'b1;
            end
          end
        end
        ST_RELEASE: begin
          if (cpu_clken) begin
            if (tick_cnt) begin
              tick_cnt     <= 1'b0;
              disp_address <= 1'b1;
              state        <= ST_GAP;
            end else begin
              tick_cnt <= 1'b1;
            end
          end
        end
        ST_GAP: begin
`ifdef TXPACE_THROTTLE_EN
          if (cpu_clken) begin
            if (pace_cnt == PACE_LAST) begin
              pace_cnt <= '0;
              state    <= ST_IDLE;
            end else begin
              pace_cnt <= pace_cnt + PACE_ONE;
            end
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_tx_pacer.sv
// tb/tb_display_tx_pacer.sv - directed self-checking bench for display_tx_pacer
module tb_display_tx_pacer;

  logic       sys_clock;
  logic       reset_n;
  logic       cpu_clken;
  logic       cpu_wr;
  logic [7:0] cpu_din;
  logic       flush;
  logic       dsp_busy;
  logic       overflow;
  logic [4:0] fifo_count;
  logic       disp_address;
  logic       disp_w_en;
  logic [7:0] disp_din;

  int n_checks = 0;
  int n_fail   = 0;

  display_tx_pacer #(.DEPTH(16), .PACE_DIV(16667)) dut (
    .sys_clock    (sys_clock),
    .reset_n      (reset_n),
    .cpu_clken    (cpu_clken),
    .cpu_wr       (cpu_wr),
    .cpu_din      (cpu_din),
    .flush        (flush),
    .dsp_busy     (dsp_busy),
    .overflow     (overflow),
    .fifo_count   (fifo_count),
    .disp_address (disp_address),
    .disp_w_en    (disp_w_en),
    .disp_din     (disp_din)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  // advance one clock and settle past the edge
  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  // wait (bounded) for the next disp_w_en rising edge and return the character seen
  task automatic wait_rise(output logic [7:0] d, output bit got);
    logic prev;
    got  = 1'b0;
    d    = 8'h00;
    prev = disp_w_en;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (disp_w_en && !prev) begin
        d   = disp_din;
        got = 1'b1;
        break;
      end
      prev = disp_w_en;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cpu_clken = 1'b0; cpu_wr = 1'b0; cpu_din = 8'h00; flush = 1'b0;
    repeat (3) tick();
    n_checks++; if (disp_w_en !== 1'b0)    begin n_fail++; $display("FAIL rst_w_en got %b exp 0", disp_w_en); end
    n_checks++; if (disp_address !== 1'b1) begin n_fail++; $display("FAIL rst_addr got %b exp 1", disp_address); end
    n_checks++; if (disp_din !== 8'h00)    begin n_fail++; $display("FAIL rst_din got %h exp 00", disp_din); end
    n_checks++; if (dsp_busy !== 1'b0)     begin n_fail++; $display("FAIL rst_busy got %b exp 0", dsp_busy); end
    n_checks++; if (overflow !== 1'b0)     begin n_fail++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    n_checks++; if (fifo_count !== 5'd0)   begin n_fail++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    reset_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    cpu_clken = 1'b1; cpu_wr = 1'b1; cpu_din = 8'hC1;
    tick();
    cpu_wr = 1'b0;
    n_checks++; if (fifo_count !== 5'd1)   begin n_fail++; $display("FAIL single_count1 got %0d exp 1", fifo_count); end
    n_checks++; if (disp_w_en !== 1'b0)    begin n_fail++; $display("FAIL single_wen_e1 got %b exp 0", disp_w_en); end
    tick();
    n_checks++; if (disp_w_en !== 1'b1)    begin n_fail++; $display("FAIL single_wen_e2 got %b exp 1", disp_w_en); end
    n_checks++; if (disp_din !== 8'hC1)    begin n_fail++; $display("FAIL single_din got %h exp c1", disp_din); end
    n_checks++; if (disp_address !== 1'b0) begin n_fail++; $display("FAIL single_addr got %b exp 0", disp_address); end
    n_checks++; if (fifo_count !== 5'd0)   begin n_fail++; $display("FAIL single_count0 got %0d exp 0", fifo_count); end
    tick();
    n_checks++; if (disp_w_en !== 1'b1)    begin n_fail++; $display("FAIL single_hold got %b exp 1", disp_w_en); end
    tick();
    n_checks++; if (disp_w_en !== 1'b0)    begin n_fail++; $display("FAIL single_release_wen got %b exp 0", disp_w_en); end
    n_checks++; if (disp_address !== 1'b0) begin n_fail++; $display("FAIL single_release_addr got %b exp 0", disp_address); end
    n_checks++; if (disp_din !== 8'hC1)    begin n_fail++; $display("FAIL single_release_din got %h exp c1", disp_din); end
    repeat (2) tick();
    n_checks++; if (disp_address !== 1'b1) begin n_fail++; $display("FAIL single_gap_addr got %b exp 1", disp_address); end
    repeat (4) tick();
  endtask

  task automatic test_fill_overflow();
    logic [7:0] d;
    bit         got;
    cpu_clken = 1'b1; cpu_wr = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cpu_din = 8'h10 + 8'(i);
      tick();
    end
    n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL fill_count got %0d exp 16", fifo_count); end
    n_checks++; if (dsp_busy !== 1'b1)    begin n_fail++; $display("FAIL fill_busy got %b exp 1", dsp_busy); end
    cpu_wr = 1'b0; cpu_clken = 1'b0;
    tick();
    n_checks++; if (fifo_count !== 5'd15) begin n_fail++; $display("FAIL fill_pop_count got %0d exp 15", fifo_count); end
    n_checks++; if (disp_din !== 8'h13)   begin n_fail++; $display("FAIL fill_pop_din got %h exp 13", disp_din); end
    cpu_clken = 1'b1; cpu_wr = 1'b1; cpu_din = 8'h40;
    tick();
    n_checks++; if (dsp_busy !== 1'b1)    begin n_fail++; $display("FAIL refill_busy got %b exp 1", dsp_busy); end
    cpu_din = 8'h41;
    tick();
    cpu_wr = 1'b0; cpu_clken = 1'b0;
    n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_set got %b exp 1", overflow); end
    n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count got %0d exp 16", fifo_count); end
    tick();
    n_checks++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_count_hold got %0d exp 16", fifo_count); end
    cpu_clken = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i < 15) ? (8'h14 + 8'(i)) : 8'h40;
      wait_rise(d, got);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL drain_timeout idx %0d got none exp %h", i, exp_d); end
      else if (d !== exp_d) begin n_fail++; $display("FAIL drain_order idx %0d got %h exp %h", i, d, exp_d); end
    end
    repeat (10) tick();
    n_checks++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL drain_empty got %0d exp 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seen [3];
    int         when [3];
    int         n;
    logic       prev;
    logic [7:0] vals [3];
    vals[0] = 8'h8D; vals[1] = 8'hC8; vals[2] = 8'hC9;
    n = 0;
    prev = disp_w_en;
    cpu_clken = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      cpu_wr  = (c <= 3);
      cpu_din = (c <= 3) ? vals[c-1] : 8'h00;
      tick();
      if (disp_w_en && !prev && n < 3) begin
        seen[n] = disp_din;
        when[n] = c;
        n++;
      end
      prev = disp_w_en;
    end
    cpu_wr = 1'b0;
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL b2b_count got %0d exp 3", n); end
    for (int k = 0; k < 3; k++) begin
      if (k < n) begin
        n_checks++;
        if (seen[k] !== vals[k]) begin n_fail++; $display("FAIL b2b_data idx %0d got %h exp %h", k, seen[k], vals[k]); end
        n_checks++;
        if (when[k] !== 2 + 6*k) begin n_fail++; $display("FAIL b2b_time idx %0d got %0d exp %0d", k, when[k], 2 + 6*k); end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_push_pop();
    logic [7:0] d;
    bit         got;
    cpu_clken = 1'b1; cpu_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cpu_din = 8'h60 + 8'(i);
      tick();
    end
    cpu_wr = 1'b0;
    tick();
    n_checks++; if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL pp_before got %0d exp 5", fifo_count); end
    cpu_wr = 1'b1; cpu_din = 8'h66;
    tick();
    cpu_wr = 1'b0;
    n_checks++; if (fifo_count !== 5'd5) begin n_fail++; $display("FAIL pp_after got %0d exp 5", fifo_count); end
    n_checks++; if (disp_din !== 8'h61)  begin n_fail++; $display("FAIL pp_pop_din got %h exp 61", disp_din); end
    for (int i = 0; i < 5; i++) begin
      wait_rise(d, got);
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL wrap_timeout idx %0d got none exp %h", i, 8'h62 + 8'(i)); end
      else if (d !== 8'h62 + 8'(i)) begin n_fail++; $display("FAIL wrap_order idx %0d got %h exp %h", i, d, 8'h62 + 8'(i)); end
    end
    repeat (10) tick();
  endtask

  task automatic test_flush();
    logic [7:0] d;
    bit         got;
    cpu_clken = 1'b1; cpu_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_din = 8'h70 + 8'(i);
      tick();
    end
    cpu_wr = 1'b0;
    wait_rise(d, got);
    n_checks++; if (!got || d !== 8'h71) begin n_fail++; $display("FAIL flush_setup got %h exp 71", d); end
    n_checks++; if (fifo_count !== 5'd3) begin n_fail++; $display("FAIL flush_queued got %0d exp 3", fifo_count); end
    cpu_clken = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (disp_w_en !== 1'b0)    begin n_fail++; $display("FAIL flush_wen got %b exp 0", disp_w_en); end
    n_checks++; if (fifo_count !== 5'd0)   begin n_fail++; $display("FAIL flush_count got %0d exp 0", fifo_count); end
    n_checks++; if (disp_address !== 1'b1) begin n_fail++; $display("FAIL flush_addr got %b exp 1", disp_address); end
    n_checks++; if (overflow !== 1'b1)     begin n_fail++; $display("FAIL flush_ovf got %b exp 1", overflow); end
    cpu_clken = 1'b1;
    repeat (4) tick();
    n_checks++; if (disp_w_en !== 1'b0)    begin n_fail++; $display("FAIL flush_idle got %b exp 0", disp_w_en); end
  endtask

  task automatic test_reset_mid_gap();
    cpu_clken = 1'b1; cpu_wr = 1'b1; cpu_din = 8'h33;
    tick();
    cpu_wr = 1'b0;
    repeat (5) tick();
    n_checks++; if (disp_address !== 1'b1 || disp_w_en !== 1'b0) begin n_fail++; $display("FAIL gap_state got addr %b wen %b exp 1 0", disp_address, disp_w_en); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (disp_din !== 8'h00)  begin n_fail++; $display("FAIL async_rst_din got %h exp 00", disp_din); end
    n_checks++; if (overflow !== 1'b0)   begin n_fail++; $display("FAIL async_rst_ovf got %b exp 0", overflow); end
    n_checks++; if (disp_address !== 1'b1 || disp_w_en !== 1'b0) begin n_fail++; $display("FAIL async_rst_strobe got addr %b wen %b exp 1 0", disp_address, disp_w_en); end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    cpu_wr = 1'b1; cpu_din = 8'h55;
    tick();
    cpu_wr = 1'b0;
    tick();
    n_checks++; if (disp_w_en !== 1'b1 || disp_din !== 8'h55) begin n_fail++; $display("FAIL post_rst got wen %b din %h exp 1 55", disp_w_en, disp_din); end
    repeat (8) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_back_to_back();
    test_push_pop();
    test_flush();
    test_reset_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
